// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (start, LSB-first data, optional parity, 1-2 stops)
module uart_tx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 2 || OVERSAMPLE > 256 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
        $error("uart_tx_param: illegal parameter value");
    end
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tick, stop_end;
    assign tick     = cnt_q == CW'(OVERSAMPLE - 1);
    // The IDLE cycle doubles as the last stop cycle, so STOP ends one cycle early and frames abut.
    assign stop_end = stop_q == 1'(STOP_BITS - 1) && cnt_q == CW'(OVERSAMPLE - 2);
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        par_d   = par_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        done_d  = 1'b0;
        cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + CW'(1);
        case (state_q)
            IDLE: if (tx_valid_i) begin
                state_d = START;
                shift_d = tx_data_i;
                par_d   = 1'b0;
                bit_d   = '0;
                stop_d  = 1'b0;
            end
            START: state_d = tick ? DATA : START;
            DATA: if (tick) begin
                shift_d = shift_q >> 1;
                par_d   = par_q ^ shift_q[0];
                bit_d   = bit_q + BW'(1);
                state_d = (bit_q == BW'(DATA_BITS - 1)) ? ((PARITY != 0) ? PAR : STOP) : DATA;
            end
            PAR: state_d = tick ? STOP : PAR;
            STOP: if (stop_end) begin
                state_d = IDLE;
                done_d  = 1'b1;
                cnt_d   = '0;
            end else if (tick) begin
                stop_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        tx_d   = (state_d == START) ? 1'b0 :
                 (state_d == DATA)  ? shift_d[0] :
                 (state_d == PAR)   ? par_d ^ (PARITY == 2) : 1'b1;
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign tx_ready_o = state_q == IDLE;
    assign tx_o       = tx_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
endmodule
